// File: rtl/sachen_indexed_mapper.sv
`timescale 1ns/1ps
// Sachen 8259-style index/data mapper with lockable CHR/PRG banking and an M2-clocked IRQ down-counter.
// Address maps are combinational from registers; register writes land on the ce edge and are seen next clk.
module sachen_indexed_mapper #(
  parameter int CHR_REGS = 4,
  parameter int BANK_W   = 3,
  parameter int PRG_W    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        enable,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  inout  wire  [21:0] prg_aout_b,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  inout  wire  [7:0]  prg_dout_b,
  inout  wire         prg_allow_b,
  input  logic [13:0] chr_ain,
  inout  wire  [21:0] chr_aout_b,
  input  logic        chr_read,
  inout  wire         chr_allow_b,
  inout  wire         vram_a10_b,
  inout  wire         vram_ce_b,
  inout  wire         irq_b,
  input  logic [15:0] audio_in,
  inout  wire  [15:0] audio_b,
  inout  wire  [15:0] flags_out_b
);

  localparam int SW  = $clog2(CHR_REGS);
  localparam int OFF = 13 - SW;
  localparam int LW  = 2 * BANK_W + OFF;

  logic [3:0]        index;
  logic [BANK_W-1:0] chr_bank [CHR_REGS];
  logic [BANK_W-1:0] outer;
  logic [PRG_W-1:0]  prg_bank;
  logic [1:0]        mirroring;
  logic [15:0]       reload;
  logic [15:0]       counter;
  logic              irq_en;
  logic              auto_reload;
  logic              pending;
  logic              lock;
  logic              zero_phase;

  logic sel;
  logic wr;
  logic idx_wr;
  logic dat_wr;
  logic cfg_wr;

  assign sel    = (prg_ain[15:13] == 3'b010) && prg_ain[8];
  assign wr     = ce && prg_write && enable && sel;
  assign idx_wr = wr && !prg_ain[0];
  assign dat_wr = wr && prg_ain[0];
  // Lock only shields the mapping registers; the IRQ block stays programmable.
  assign cfg_wr = dat_wr && !(lock && (index <= 4'd10));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index <= '0;
      for (int i = 0; i < CHR_REGS; i++) chr_bank[i] <= '0;
      outer       <= '0;
      prg_bank    <= '0;
      mirroring   <= '0;
      reload      <= '0;
      counter     <= '0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      pending     <= 1'b0;
      lock        <= 1'b0;
      zero_phase  <= 1'b0;
    end else begin
      if (ce && enable && irq_en) begin
        if (counter != 16'd0) begin
          counter    <= counter - 16'd1;
          zero_phase <= 1'b0;
          if (counter == 16'd1) pending <= 1'b1;
        end else if (auto_reload) begin
          counter <= reload;
          // A zero reload alternates reload and terminal ce, so IRQ fires every other ce.
          if (reload == 16'd0) begin
            zero_phase <= !zero_phase;
            if (zero_phase) pending <= 1'b1;
          end
        end else begin
          irq_en <= 1'b0;
        end
      end

      if (idx_wr) index <= prg_din[3:0];

      // Placed after the counter update so a same-edge control/ack write wins over terminal count.
      if (cfg_wr) begin
        for (int i = 0; i < CHR_REGS; i++)
          if (index == 4'(i)) chr_bank[i] <= prg_din[BANK_W-1:0];
        case (index)
          4'd8:  outer       <= prg_din[BANK_W-1:0];
          4'd9:  prg_bank    <= prg_din[PRG_W-1:0];
          4'd10: mirroring   <= prg_din[1:0];
          4'd11: reload[7:0]  <= prg_din;
          4'd12: reload[15:8] <= prg_din;
          4'd13: begin
            irq_en      <= prg_din[0];
            auto_reload <= prg_din[1];
            counter     <= reload;
            pending     <= 1'b0;
            zero_phase  <= 1'b0;
          end
          4'd14: pending <= 1'b0;
          4'd15: if (prg_din[0]) lock <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  logic [7:0] data_rd;
  always_comb begin
    data_rd = 8'h00;
    for (int i = 0; i < CHR_REGS; i++)
      if (index == 4'(i)) data_rd = 8'(chr_bank[i]);
    case (index)
      4'd8:  data_rd = 8'(outer);
      4'd9:  data_rd = 8'(prg_bank);
      4'd10: data_rd = {6'd0, mirroring};
      4'd11: data_rd = reload[7:0];
      4'd12: data_rd = reload[15:8];
      4'd13: data_rd = {5'd0, pending, auto_reload, irq_en};
      4'd14, 4'd15: data_rd = {7'd0, lock};
      default: ;
    endcase
  end

  logic [7:0]        prg_dout;
  logic [21:0]       prg_aout;
  logic [21:0]       chr_aout;
  logic [BANK_W-1:0] slot_bank;
  logic [LW-1:0]     chr_low;
  logic              vram_a10;

  assign prg_dout  = prg_ain[0] ? data_rd : {4'b0011, ~index};
  assign prg_aout  = 22'({prg_bank, prg_ain[14:0]});
  assign slot_bank = chr_bank[chr_ain[12 -: SW]];
  assign chr_low   = {outer, slot_bank, chr_ain[OFF-1:0]};

  generate
    if (LW <= 20) begin : g_chr_fit
      assign chr_aout = 22'(chr_low) | 22'h200000;
    end else begin : g_chr_trunc
      assign chr_aout = 22'({2'b10, chr_low});
    end
  endgenerate

  always_comb begin
    vram_a10 = chr_ain[10];
    case (mirroring)
      2'd0: vram_a10 = chr_ain[10];
      2'd1: vram_a10 = chr_ain[11];
      2'd2: vram_a10 = 1'b0;
      2'd3: vram_a10 = 1'b1;
      default: ;
    endcase
  end

  assign prg_aout_b  = enable ? prg_aout : 'z;
  assign prg_dout_b  = enable ? prg_dout : 'z;
  assign prg_allow_b = enable ? (prg_ain[15] && !prg_write) : 1'bz;
  assign chr_aout_b  = enable ? chr_aout : 'z;
  assign chr_allow_b = enable ? flags[15] : 1'bz;
  assign vram_a10_b  = enable ? vram_a10 : 1'bz;
  assign vram_ce_b   = enable ? chr_ain[13] : 1'bz;
  assign irq_b       = enable ? pending : 1'bz;
  assign audio_b     = enable ? {1'b0, audio_in[15:1]} : 'z;
  assign flags_out_b = enable ? {14'd0, sel, 1'b0} : 'z;

  logic unused_inputs;
  assign unused_inputs = ^{prg_read, chr_read, flags[31:16], flags[14:0], audio_in[0]};

endmodule

// File: doc/sachen_indexed_mapper.md
# sachen_indexed_mapper

Parametrised successor to the Sachen 8259-family mappers, instantiated alongside the other mapper modules on the shared tristate cart bus. It provides:
- an index/data register pair at $4100/$4101 with a configurable number of CHR bank slots and bank width,
- four-way mirroring control,
- a write-lock,
- a 16-bit M2-clocked IRQ down-counter the 8259 family lacks.

Outputs are driven only while `enable` is high; otherwise every `_b` port is high-Z.

## Interface
- CHR_REGS, 4, number of CHR slot registers. Legal values: 2, 4, 8. Slot size = 8 KB / CHR_REGS.
- BANK_W, 3, width of each CHR slot register and of the outer CHR register. Legal range 3..8.
- PRG_W, 3, width of the 32 KB PRG bank register. Legal range 1..7.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  M2 cycle enable
- enable  in  1  mapper selected
- flags  in  32  cart flags; bit 15 = CHR RAM write allow
- prg_ain  in  16  CPU address
- prg_aout_b  inout  22  PRG address out
- prg_read / prg_write  in  1 each  CPU strobes
- prg_din  in  8  CPU write data
- prg_dout_b  inout  8  readback data
- prg_allow_b  inout  1  PRG memory access allow
- chr_ain  in  14  PPU address
- chr_aout_b  inout  22  CHR address out
- chr_read  in  1  PPU read
- chr_allow_b  inout  1  CHR write allow
- vram_a10_b / vram_ce_b  inout  1 each  CIRAM A10 / CIRAM select
- irq_b  inout  1  IRQ, active high
- audio_in  in  16  APU audio
- audio_b  inout  16  audio out = {0, audio_in[15:1]}
- flags_out_b  inout  16  {14'd0, prg_bus_write, 0}

## Operation
- Register decode uses `sel = (prg_ain[15:13]==3'b010) && prg_ain[8]`.
  - Index port: `sel && !prg_ain[0]`. A write loads `index[3:0] <= prg_din[3:0]`.
  - Data port: `sel && prg_ain[0]`. A write loads register `index`.
- Data-port register map:
  - 0..CHR_REGS-1: CHR slot banks, from prg_din[BANK_W-1:0].
  - 8: outer CHR.
  - 9: PRG bank.
  - 10: mirroring[1:0].
  - 11: IRQ reload low byte.
  - 12: IRQ reload high byte.
  - 13: IRQ control. Bit0 = irq_en, bit1 = auto_reload. The write also copies reload into the counter and clears pending.
  - 14: IRQ ack (any value) clears pending.
  - 15: bit0 = 1 sets lock.
  - Unmapped indices are ignored.
- Lock: while lock=1, data writes to indices 0..10 are ignored. IRQ registers (11..14) stay writable. Only reset clears lock.
- Readback (prg_bus_write = sel):
  - Index port returns {4'b0011, ~index}.
  - Data port returns the selected register zero-extended to 8 bits. Reload high/low return reload bytes. Index 13 returns {5'b0, pending, auto_reload, irq_en}. Indices 14/15 return {7'b0, lock}.
- PRG mapping:
  - prg_aout = {zero-pad, prg_bank, prg_ain[14:0]} (22 bits total).
  - prg_allow = prg_ain[15] && !prg_write.
- CHR mapping:
  - Slot = chr_ain[12 -: log2(CHR_REGS)].
  - chr_aout = {2'b10, zero-pad, outer, slot_bank, chr_ain[offset bits]} (22 bits; truncate high bits if they overflow).
  - chr_allow = flags[15].
- Nametables: vram_ce = chr_ain[13]. vram_a10 by mirroring value:
  - 0 → chr_ain[10] (vertical)
  - 1 → chr_ain[11] (horizontal)
  - 2 → 0
  - 3 → 1
- IRQ behaviour, on each clk with ce=1 and irq_en=1:
  - If counter ≠ 0: counter decrements. A transition 1→0 sets pending.
  - If counter = 0: with auto_reload, counter <= reload; without it, irq_en <= 0.
  - Reload = 0 with auto_reload: pending sets on each reload-then-zero, i.e. every other ce.
  - irq_b = pending.

## Timing
- Reset (asynchronous, reset_n low) clears index, all banks, mirroring, reload, counter, irq_en, auto_reload, pending and lock to 0.
  - Resulting outputs: prg_aout bank 0, vertical mirroring, irq low.
  - Reset mid-count drops IRQ immediately, without waiting for clk.
- All register writes are sampled on the clk edge where ce && prg_write && enable. The new mapping is visible on outputs from the next clk. Address/data outputs are combinational from the registers.
- pending is registered: irq_b rises one clk after the ce edge that reaches 0.
- Simultaneous terminal count and a write to 13 or 14 on the same ce: the write wins and pending stays 0.
- enable low freezes nothing: registers keep their state, only outputs tri-state. The IRQ counter runs only while enable=1.

## Test plan
- Reset release: write index 9 = 5 → PRG fetch at $8123 gives prg_aout = 0x28123. Read $4100 with index=9 → 0x36.
- CHR_REGS=4, BANK_W=3: write index 2 = 6, outer = 1 → chr_ain 0x1234 maps to chr_aout = {2'b10, …, 1, 6, 0x234}; check the exact 22-bit value.
- Write mirroring 0..3 → vram_a10 follows A10, A11, constant 0, constant 1.
- IRQ: reload = 0x0003, control = 0x01 → irq_b rises one clk after the 3rd ce. Further ce leave the counter at 0 and clear irq_en. Ack → irq_b low next clk.
- Auto-reload with reload = 2 → pending sets on ce 2; after ack, sets again on ce 5. A control write coinciding with terminal count leaves pending 0.
- Lock: write 15 = 1, then index 9 = 7 → PRG bank unchanged. IRQ reload writes still take effect. Async reset_n pulse mid-count → irq_b low immediately and lock cleared.
